data_pack: RTL

DATA_PACK -- requirements
Module: data_pack

---
 rtl/data_pack.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/data_pack.sv
// Packs 7-bit symbols LSB-first into 32-bit words with sop/eop framing and a one-entry output register.
// Optional feature: define DATA_PACK_ERR_CNT_EN to add the saturating err_cnt output.
module data_pack (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        sop_in,
    input  logic        eop_in,
    input  logic [6:0]  data_in,
    output logic        ready_out,
    input  logic        ready_in,
    output logic        valid_out,
    output logic        sop_out,
    output logic        eop_out,
    output logic [31:0] data_out,
    output logic [5:0]  valid_bits_out
`ifdef DATA_PACK_ERR_CNT_EN
    ,
    output logic [7:0]  err_cnt
`endif
);

    // Fill count never exceeds 31 + 7, so 39 bits of accumulator suffice.
    localparam int ACC_W = 39;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            state_reg;
    logic [ACC_W-1:0]  acc_reg;
    logic [5:0]        cnt_reg;
    logic              sop_pending_reg;
    logic              ready_reg;
    logic              valid_reg;
    logic              sop_reg;
    logic              eop_reg;
    logic [31:0]       data_reg;
    logic [5:0]        bits_reg;

    logic              accept;
    logic              slot_free;
    logic [ACC_W-1:0]  acc_appended;
    logic [ACC_W-1:0]  acc_shifted;
    logic [5:0]        cnt_plus;
    logic [5:0]        cnt_minus;
    logic [31:0]       tail_mask;

    assign accept       = valid_in & ready_reg;
    assign slot_free    = ~valid_reg | ready_in;
    assign acc_appended = acc_reg | (ACC_W'(data_in) << cnt_reg);
    assign acc_shifted  = acc_reg >> 32;
    assign cnt_plus     = cnt_reg + 6'd7;
    assign cnt_minus    = cnt_reg - 6'd32;

    // Final word keeps only the bits below the fill count.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_mask
            assign tail_mask[gi] = (6'(gi) < cnt_reg);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            acc_reg         <= '0;
            cnt_reg         <= '0;
            sop_pending_reg <= 1'b0;
            ready_reg       <= 1'b0;
            valid_reg       <= 1'b0;
            sop_reg         <= 1'b0;
            eop_reg         <= 1'b0;
            data_reg        <= '0;
            bits_reg        <= '0;
        end else begin
            if (slot_free) begin
                valid_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    ready_reg <= 1'b1;
                    if (accept && sop_in) begin
                        acc_reg         <= ACC_W'(data_in);
                        cnt_reg         <= 6'd7;
                        sop_pending_reg <= 1'b1;
                        if (eop_in) begin
                            state_reg <= FLUSH;
                            ready_reg <= 1'b0;
                        end else begin
                            state_reg <= PACK;
                        end
                    end
                end
                PACK: begin
                    if (cnt_reg >= 6'd32) begin
                        if (slot_free) begin
                            valid_reg       <= 1'b1;
                            data_reg        <= acc_reg[31:0];
                            bits_reg        <= 6'd32;
                            sop_reg         <= sop_pending_reg;
                            eop_reg         <= 1'b0;
                            sop_pending_reg <= 1'b0;
                            acc_reg         <= acc_shifted;
                            cnt_reg         <= cnt_minus;
                            ready_reg       <= 1'b1;
                        end
                    end else if (accept) begin
                        acc_reg <= acc_appended;
                        cnt_reg <= cnt_plus;
                        if (eop_in) begin
                            state_reg <= FLUSH;
                            ready_reg <= 1'b0;
                        end else begin
                            ready_reg <= (cnt_plus < 6'd32);
                        end
                    end
                end
                FLUSH: begin
                    if (slot_free) begin
                        valid_reg       <= 1'b1;
                        sop_reg         <= sop_pending_reg;
                        sop_pending_reg <= 1'b0;
                        if (cnt_reg > 6'd32) begin
                            data_reg <= acc_reg[31:0];
                            bits_reg <= 6'd32;
                            eop_reg  <= 1'b0;
                            acc_reg  <= acc_shifted;
                            cnt_reg  <= cnt_minus;
                        end else begin
                            data_reg  <= acc_reg[31:0] & tail_mask;
                            bits_reg  <= cnt_reg;
                            eop_reg   <= 1'b1;
                            acc_reg   <= '0;
                            cnt_reg   <= '0;
                            state_reg <= IDLE;
                            ready_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef DATA_PACK_ERR_CNT_EN
    logic       err_event;
    logic [7:0] err_cnt_reg;

    // Dropped symbol outside a packet, or a stray sop inside one.
    assign err_event = accept & (((state_reg == IDLE) & ~sop_in) |
                                 ((state_reg == PACK) & sop_in));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_reg <= '0;
        end else if (err_event && (err_cnt_reg != 8'hFF)) begin
            err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end

    assign err_cnt = err_cnt_reg;
`endif

    assign ready_out      = ready_reg;
    assign valid_out      = valid_reg;
    assign sop_out        = sop_reg;
    assign eop_out        = eop_reg;
    assign data_out       = data_reg;
    assign valid_bits_out = bits_reg;

endmodule
